digital_lock_seq: RTL



---
 rtl/digital_lock_pkg.sv | 22 ++
 rtl/digital_lock_seq_timer.sv | 27 ++
 rtl/digital_lock_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/digital_lock_pkg.sv
// Shared definitions for the digital_lock_seq combination lock: state encoding
// and a digit extractor for flattened code vectors.
package digital_lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  localparam int CODE_VEC_W = 256;

  // Digit idx of a code vector whose digit 0 sits in the low bits.
  function automatic logic [31:0] code_digit(input logic [CODE_VEC_W-1:0] vec,
                                             input int width, input int idx);
    logic [CODE_VEC_W-1:0] sh;
    sh = vec >> (idx * width);
    return sh[31:0] & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/digital_lock_seq_timer.sv
// lock_timer: loadable down-counter, done while the count sits at one so the
// owner leaves its state on the edge that consumes the final cycle.
module lock_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/digital_lock_seq.sv
// Parametrised combination lock with timed unlock and fail lockout.
// Optional code programming while OPEN when DIGITAL_LOCK_PROGRAM_EN is defined.
//
//   state      | meaning
//   IDLE       | waiting for digit 0
//   ENTRY      | partial code matched, progress = digits so far
//   OPEN       | y high, timer counting OPEN_CYCLES, lock forces relock
//   LOCKOUT    | inputs ignored for LOCKOUT_CYCLES after MAX_FAILS wrong digits
module digital_lock_seq
  import digital_lock_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 3,
  parameter logic [DEPTH*WIDTH-1:0] CODE = 9'b101_111_011,
  parameter int OPEN_CYCLES = 8,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic [WIDTH-1:0] x,
  input  logic x_valid,
  input  logic lock,
`ifdef DIGITAL_LOCK_PROGRAM_EN
  input  logic prog_we,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] prog_idx,
  input  logic [WIDTH-1:0] prog_data,
`endif
  output logic y,
  output logic [1:0] state,
  output logic [$clog2(DEPTH+1)-1:0] progress,
  output logic lockout,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

  localparam int PW   = $clog2(DEPTH + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  state_t            r_state;
  logic              r_y;
  logic              r_lockout;
  logic [PW-1:0]     r_progress;
  logic [FW-1:0]     r_fail_cnt;

  logic [DEPTH*WIDTH-1:0] w_code;
  logic [WIDTH-1:0]  w_expect;
  logic              w_entry;
  logic              w_match;
  logic              w_last;
  logic              w_fail_max;
  logic              w_tmr_load;
  logic              w_tmr_en;
  logic              w_tmr_done;
  logic [TW-1:0]     w_tmr_val;

`ifdef DIGITAL_LOCK_PROGRAM_EN
  logic [DEPTH*WIDTH-1:0] r_code;

  always_ff @(posedge clk) begin
    if (reset)
      r_code <= CODE;
    else if (prog_we && r_state == ST_OPEN && int'(prog_idx) < DEPTH)
      r_code[int'(prog_idx)*WIDTH +: WIDTH] <= prog_data;
  end

  assign w_code = r_code;
`else
  assign w_code = CODE;
`endif

  assign w_expect   = WIDTH'(code_digit(CODE_VEC_W'(w_code), WIDTH, int'(r_progress)));
  assign w_entry    = (r_state == ST_IDLE) || (r_state == ST_ENTRY);
  assign w_match    = (x == w_expect);
  assign w_last     = (int'(r_progress) == DEPTH - 1);
  assign w_fail_max = (int'(r_fail_cnt) + 1 >= MAX_FAILS);

  // OPEN and LOCKOUT never overlap, so one timer serves both.
  assign w_tmr_load = w_entry && x_valid && ((w_match && w_last) || (!w_match && w_fail_max));
  assign w_tmr_val  = w_match ? TW'(OPEN_CYCLES) : TW'(LOCKOUT_CYCLES);
  assign w_tmr_en   = (r_state == ST_OPEN) || (r_state == ST_LOCKOUT);

  lock_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_tmr_load),
    .i_load_val(w_tmr_val),
    .i_en      (w_tmr_en),
    .o_done    (w_tmr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_y        <= 1'b0;
      r_progress <= '0;
      r_lockout  <= 1'b0;
      r_fail_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ENTRY: begin
          if (x_valid) begin
            if (w_match) begin
              if (w_last) begin
                r_state    <= ST_OPEN;
                r_y        <= 1'b1;
                r_progress <= '0;
                r_fail_cnt <= '0;
              end else begin
                r_state    <= ST_ENTRY;
                r_progress <= r_progress + 1'b1;
              end
            end else begin
              r_progress <= '0;
              if (w_fail_max) begin
                r_state    <= ST_LOCKOUT;
                r_lockout  <= 1'b1;
                r_fail_cnt <= FW'(MAX_FAILS);
              end else begin
                r_state    <= ST_IDLE;
                r_fail_cnt <= r_fail_cnt + 1'b1;
              end
            end
          end
        end
        ST_OPEN: begin
          if (lock || w_tmr_done) begin
            r_state <= ST_IDLE;
            r_y     <= 1'b0;
          end
        end
        ST_LOCKOUT: begin
          if (w_tmr_done) begin
            r_state    <= ST_IDLE;
            r_lockout  <= 1'b0;
            r_fail_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign y        = r_y;
  assign state    = r_state;
  assign progress = r_progress;
  assign lockout  = r_lockout;
  assign fail_cnt = r_fail_cnt;

endmodule
